// File: rtl/multi_fan_ctrl_pkg.sv
// Shared definitions for the multi-channel fan controller: stall FSM
// encoding, saturation constants and the proportional auto-duty helper.
package multi_fan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_KICK    = 2'd2
  } fan_state_t;

  localparam logic [11:0] DUTY_FULL = 12'hFFF;
  localparam logic [15:0] RPM_SAT   = 16'hFFFF;
  localparam logic [9:0]  EDGE_SAT  = 10'd1023;

  // Floor duty at or below target; above it the error is scaled onto the
  // floor in 17 bits so the clamp sees the true sum.
  function automatic logic [11:0] calc_auto_duty(
    input logic [11:0] temp,
    input logic [11:0] temp_target,
    input logic [11:0] duty_min,
    input logic [11:0] duty_max,
    input int unsigned kp_shift
  );
    logic signed [12:0] err;
    logic        [16:0] sum;
    err = $signed({1'b0, temp}) - $signed({1'b0, temp_target});
    sum = {5'd0, duty_min} + ({5'd0, err[11:0]} << kp_shift);
    if (err <= 13'sd0)
      calc_auto_duty = duty_min;
    else if (sum > {5'd0, duty_max})
      calc_auto_duty = duty_max;
    else
      calc_auto_duty = sum[11:0];
  endfunction

endpackage

// File: rtl/multi_fan_ctrl_channel.sv
// One fan channel: tach synchroniser (plus optional deglitch filter when
// FAN_TACH_DEGLITCH_EN is defined), edge counter, RPM latch, stall/kick
// FSM, wrap-aligned duty load and PWM compare.
module multi_fan_ctrl_channel
  import multi_fan_ctrl_pkg::*;
#(
  parameter int RPM_MUL   = 60,
  parameter int STALL_RPM = 300,
  parameter int STALL_WIN = 3,
  parameter int KICK_WIN  = 2
`ifdef FAN_TACH_DEGLITCH_EN
  , parameter int DEGLITCH_CYC = 16
`endif
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        tach,
  input  logic        mode,
  input  logic [11:0] manual_duty,
  input  logic [11:0] auto_duty,
  input  logic [11:0] pwm_cnt,
  input  logic        pwm_wrap,
  input  logic        win_end,
  output logic        pwm,
  output logic [11:0] duty,
  output logic [15:0] rpm,
  output logic        stall
);

  logic        tach_s1, tach_s2, tach_f, tach_prev, tach_rise;
  logic [9:0]  edges;
  logic [31:0] rpm_prod;
  logic [15:0] rpm_new;
  logic        low;
  logic [11:0] req_duty;
  fan_state_t  state, state_nxt;
  logic [7:0]  low_cnt, low_cnt_nxt, kick_cnt, kick_cnt_nxt;
  logic        stall_nxt;

  // Two-flop synchroniser for the asynchronous open-collector tach input.
  // NOTE: rstn is sampled inside the clocked body (synchronous reset), and all
  // state here uses <= so every flop sees pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tach_s1 <= 1'b0;
      tach_s2 <= 1'b0;
    end else begin
      tach_s1 <= tach;
      tach_s2 <= tach_s1;
    end
  end

`ifdef FAN_TACH_DEGLITCH_EN
  localparam int DG_W = $clog2(DEGLITCH_CYC + 1);
  logic [DG_W-1:0] dg_cnt;
  logic            tach_filt;

  // Filtered level follows the synchronised tach only after it has held a
  // new level for DEGLITCH_CYC consecutive cycles.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      dg_cnt    <= '0;
      tach_filt <= 1'b0;
    end else if (tach_s2 == tach_filt) begin
      dg_cnt <= '0;
    end else if (dg_cnt == DG_W'(DEGLITCH_CYC - 1)) begin
      tach_filt <= tach_s2;
      dg_cnt    <= '0;
    end else begin
      dg_cnt <= dg_cnt + 1'b1;
    end
  end
  assign tach_f = tach_filt;
`else
  assign tach_f = tach_s2;
`endif

  assign tach_rise = tach_f & ~tach_prev;
  assign rpm_prod  = 32'(edges) * 32'(RPM_MUL);
  assign rpm_new   = (rpm_prod > 32'(RPM_SAT)) ? RPM_SAT : rpm_prod[15:0];
  assign low       = (rpm_new < 16'(STALL_RPM));
  assign req_duty  = mode ? manual_duty : auto_duty;

  // Rising-edge counter; an edge in the window-end cycle seeds the new window.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tach_prev <= 1'b0;
      edges     <= '0;
      rpm       <= '0;
    end else begin
      tach_prev <= tach_f;
      if (win_end) begin
        edges <= {9'd0, tach_rise};
        rpm   <= rpm_new;
      end else if (tach_rise && edges != EDGE_SAT) begin
        edges <= edges + 10'd1;
      end
    end
  end

  // Stall FSM next state: acts on window ends, except that a zero request
  // parks the channel in RUN immediately since a stopped fan is not a stall.
  // NOTE: every output gets its hold value first so no path infers a latch.
  always_comb begin
    state_nxt    = state;
    low_cnt_nxt  = low_cnt;
    kick_cnt_nxt = kick_cnt;
    stall_nxt    = stall;
    if (req_duty == 12'd0) begin
      state_nxt    = ST_RUN;
      low_cnt_nxt  = '0;
      kick_cnt_nxt = '0;
      stall_nxt    = 1'b0;
    end else if (win_end) begin
      case (state)
        ST_RUN: begin
          if (low) begin
            if (STALL_WIN <= 1) begin
              state_nxt    = ST_KICK;
              stall_nxt    = 1'b1;
              kick_cnt_nxt = '0;
            end else begin
              state_nxt   = ST_SUSPECT;
              low_cnt_nxt = 8'd1;
            end
          end
        end
        ST_SUSPECT: begin
          if (!low) begin
            state_nxt   = ST_RUN;
            low_cnt_nxt = '0;
          end else if (low_cnt + 8'd1 == 8'(STALL_WIN)) begin
            state_nxt    = ST_KICK;
            stall_nxt    = 1'b1;
            kick_cnt_nxt = '0;
            low_cnt_nxt  = '0;
          end else begin
            low_cnt_nxt = low_cnt + 8'd1;
          end
        end
        ST_KICK: begin
          if (kick_cnt + 8'd1 == 8'(KICK_WIN)) begin
            kick_cnt_nxt = '0;
            if (!low) begin
              state_nxt = ST_RUN;
              stall_nxt = 1'b0;
            end
          end else begin
            kick_cnt_nxt = kick_cnt + 8'd1;
          end
        end
        default: state_nxt = ST_RUN;
      endcase
    end
  end

  // Stall FSM state register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= ST_RUN;
      low_cnt  <= '0;
      kick_cnt <= '0;
      stall    <= 1'b0;
    end else begin
      state    <= state_nxt;
      low_cnt  <= low_cnt_nxt;
      kick_cnt <= kick_cnt_nxt;
      stall    <= stall_nxt;
    end
  end

  // Duty changes only at the counter wrap, so a period is never cut short.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      duty <= '0;
      pwm  <= 1'b0;
    end else begin
      if (pwm_wrap)
        duty <= (state == ST_KICK && req_duty != 12'd0) ? DUTY_FULL : req_duty;
      pwm <= (duty == DUTY_FULL) || (pwm_cnt < duty);
    end
  end

endmodule

// File: rtl/multi_fan_ctrl.sv
// N-channel closed-loop fan controller top: auto-duty arithmetic, shared
// PWM counter/prescaler and RPM window timer feeding N fan channels.
// Define FAN_TACH_DEGLITCH_EN to enable the tach deglitch filter.
module multi_fan_ctrl
  import multi_fan_ctrl_pkg::*;
#(
  parameter int N_FAN      = 2,
  parameter int PWM_PRESC  = 1,
  parameter int WIN_CYCLES = 25_000_000,
  parameter int RPM_MUL    = 60,
  parameter int DUTY_MIN   = 800,
  parameter int DUTY_MAX   = 4095,
  parameter int KP_SHIFT   = 4,
  parameter int STALL_RPM  = 300,
  parameter int STALL_WIN  = 3,
  parameter int KICK_WIN   = 2
`ifdef FAN_TACH_DEGLITCH_EN
  , parameter int DEGLITCH_CYC = 16
`endif
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [11:0]         temp,
  input  logic [11:0]         temp_target,
  input  logic [N_FAN-1:0]    mode,
  input  logic [12*N_FAN-1:0] manual_duty,
  input  logic [N_FAN-1:0]    tach,
  output logic [N_FAN-1:0]    pwm,
  output logic [12*N_FAN-1:0] duty,
  output logic [16*N_FAN-1:0] rpm,
  output logic                rpm_valid,
  output logic [N_FAN-1:0]    stall
);

  localparam int PRESC_W = (PWM_PRESC > 1) ? $clog2(PWM_PRESC) : 1;
  localparam int WIN_W   = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;

  logic [11:0]        auto_duty;
  logic [PRESC_W-1:0] presc_cnt;
  logic [11:0]        pwm_cnt;
  logic               pwm_tick, pwm_wrap;
  logic [WIN_W-1:0]   win_cnt;
  logic               win_end;

  assign pwm_tick = (presc_cnt == PRESC_W'(PWM_PRESC - 1));
  assign pwm_wrap = pwm_tick && (pwm_cnt == DUTY_FULL);
  assign win_end  = (win_cnt == WIN_W'(WIN_CYCLES - 1));

  // Registered auto target shared by every channel in auto mode.
  always_ff @(posedge clk) begin
    if (!rstn)
      auto_duty <= '0;
    else
      auto_duty <= calc_auto_duty(temp, temp_target, 12'(DUTY_MIN),
                                  12'(DUTY_MAX), KP_SHIFT);
  end

  // Prescaled 12-bit PWM counter common to all channels.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
    end else if (pwm_tick) begin
      presc_cnt <= '0;
      pwm_cnt   <= pwm_cnt + 12'd1;
    end else begin
      presc_cnt <= presc_cnt + 1'b1;
    end
  end

  // RPM measurement window timer and its end-of-window strobe.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      win_cnt   <= '0;
      rpm_valid <= 1'b0;
    end else begin
      win_cnt   <= win_end ? '0 : win_cnt + 1'b1;
      rpm_valid <= win_end;
    end
  end

  for (genvar i = 0; i < N_FAN; i++) begin : g_ch
    multi_fan_ctrl_channel #(
      .RPM_MUL   (RPM_MUL),
      .STALL_RPM (STALL_RPM),
      .STALL_WIN (STALL_WIN),
      .KICK_WIN  (KICK_WIN)
`ifdef FAN_TACH_DEGLITCH_EN
      , .DEGLITCH_CYC(DEGLITCH_CYC)
`endif
    ) u_ch (
      .clk         (clk),
      .rstn        (rstn),
      .tach        (tach[i]),
      .mode        (mode[i]),
      .manual_duty (manual_duty[12*i +: 12]),
      .auto_duty   (auto_duty),
      .pwm_cnt     (pwm_cnt),
      .pwm_wrap    (pwm_wrap),
      .win_end     (win_end),
      .pwm         (pwm[i]),
      .duty        (duty[12*i +: 12]),
      .rpm         (rpm[16*i +: 16]),
      .stall       (stall[i])
    );
  end

endmodule
